// File: rtl/mmc_rd_sequencer.sv
// mmc_rd_sequencer: sequences MMC CMD17/CMD18 block reads, streams 512 bytes per block, closes multi-block reads with CMD12
// Ports: host_* start/busy/done/err handshake; out_* byte stream (valid/ready);
//   cmd_* command engine interface; rd_* byte-serial read engine interface.
// Optional feature: define MMC_RD_TIMEOUT_EN to enable the rd_ack timeout (TIMEOUT_CYCLES, err 2).
module mmc_rd_sequencer #(
  parameter int BYTE_ADDR = 1
`ifdef MMC_RD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1048575
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_start_i,
  input  logic [31:0] host_addr_i,
  input  logic [15:0] host_nblk_i,
  output logic        host_busy_o,
  output logic        host_done_o,
  output logic [1:0]  host_err_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        cmd_start_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  input  logic        cmd_done_i,
  input  logic        cmd_err_i,
  output logic        rd_enable_o,
  output logic        rd_req_o,
  input  logic        rd_ack_i,
  input  logic [7:0]  rd_data_i
);
  typedef enum logic [2:0] {IDLE, CMD, XFER, STOP, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] nblk_q, nblk_d, blk_q, blk_d;
  logic [9:0]  bidx_q, bidx_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        cmd_start_q, cmd_start_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        rd_enable_q, rd_enable_d;
  logic        rd_req_q, rd_req_d;
  logic        pend_q, pend_d;
  logic        fin_q, fin_d;
`ifdef MMC_RD_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nblk_q      <= '0;
      blk_q       <= '0;
      bidx_q      <= '0;
      err_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cmd_start_q <= 1'b0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
      rd_enable_q <= 1'b0;
      rd_req_q    <= 1'b0;
      pend_q      <= 1'b0;
      fin_q       <= 1'b0;
`ifdef MMC_RD_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      nblk_q      <= nblk_d;
      blk_q       <= blk_d;
      bidx_q      <= bidx_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cmd_start_q <= cmd_start_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      rd_enable_q <= rd_enable_d;
      rd_req_q    <= rd_req_d;
      pend_q      <= pend_d;
      fin_q       <= fin_d;
`ifdef MMC_RD_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end
  always_comb begin
    state_d     = state_q;
    nblk_d      = nblk_q;
    blk_d       = blk_q;
    bidx_d      = bidx_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready_i;
    cmd_start_d = 1'b0;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    rd_enable_d = rd_enable_q;
    rd_req_d    = 1'b0;
    pend_d      = pend_q;
    fin_d       = fin_q;
`ifdef MMC_RD_TIMEOUT_EN
    tmo_d       = (state_q == XFER && pend_q && !rd_ack_i) ? tmo_q + 32'd1 : 32'd0;
`endif
    case (state_q)
      IDLE: if (host_start_i) begin
        nblk_d      = host_nblk_i;
        blk_d       = '0;
        bidx_d      = '0;
        err_d       = 2'd0;
        fin_d       = 1'b0;
        pend_d      = 1'b0;
        cmd_start_d = host_nblk_i != 16'd0;
        cmd_index_d = host_nblk_i == 16'd1 ? 6'd17 : 6'd18;
        cmd_arg_d   = BYTE_ADDR != 0 ? {host_addr_i[22:0], 9'd0} : host_addr_i;
        state_d     = host_nblk_i == 16'd0 ? DONE : CMD;
      end
      CMD: if (cmd_done_i) begin
        state_d     = cmd_err_i ? DONE : XFER;
        err_d       = cmd_err_i ? 2'd1 : 2'd0;
        rd_enable_d = !cmd_err_i;
      end
      XFER: begin
        // fin_q: last trailer consumed; hold here until the final byte has drained
        if (fin_q) begin
          if (!out_valid_q) begin
            fin_d       = 1'b0;
            state_d     = nblk_q > 16'd1 ? STOP : DONE;
            cmd_start_d = nblk_q > 16'd1;
            cmd_index_d = nblk_q > 16'd1 ? 6'd12 : cmd_index_q;
            cmd_arg_d   = nblk_q > 16'd1 ? 32'd0 : cmd_arg_q;
          end
        end else if (rd_ack_i && pend_q) begin
          pend_d = 1'b0;
          // bidx 512..514 are CRC hi/lo and end token, silently dropped
          if (!bidx_q[9]) begin
            out_data_d  = rd_data_i;
            out_valid_d = 1'b1;
          end
          bidx_d = bidx_q == 10'd514 ? 10'd0 : bidx_q + 10'd1;
          if (bidx_q == 10'd514) begin
            blk_d = blk_q + 16'd1;
            if (blk_q == nblk_q - 16'd1) begin
              rd_enable_d = 1'b0;
              fin_d       = 1'b1;
            end
          end
`ifdef MMC_RD_TIMEOUT_EN
        end else if (pend_q && tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
          pend_d      = 1'b0;
          rd_enable_d = 1'b0;
          out_valid_d = 1'b0;
          err_d       = 2'd2;
          state_d     = nblk_q > 16'd1 ? STOP : DONE;
          cmd_start_d = nblk_q > 16'd1;
          cmd_index_d = nblk_q > 16'd1 ? 6'd12 : cmd_index_q;
          cmd_arg_d   = nblk_q > 16'd1 ? 32'd0 : cmd_arg_q;
`endif
        end else if (!pend_q && (bidx_q[9] || !out_valid_q)) begin
          rd_req_d = 1'b1;
          pend_d   = 1'b1;
        end
      end
      STOP: if (cmd_done_i) begin
        state_d = DONE;
        // a timeout error outranks the CMD12 response status
        err_d   = err_q == 2'd2 ? 2'd2 : {1'b0, cmd_err_i};
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign host_busy_o = state_q inside {CMD, XFER, STOP};
  assign host_done_o = state_q == DONE;
  assign host_err_o  = err_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign cmd_start_o = cmd_start_q;
  assign cmd_index_o = cmd_index_q;
  assign cmd_arg_o   = cmd_arg_q;
  assign rd_enable_o = rd_enable_q;
  assign rd_req_o    = rd_req_q;
endmodule

// File: tb/tb_mmc_rd_sequencer.sv
// tb_mmc_rd_sequencer: directed bench with behavioural command/read engines and a byte sink
module tb_mmc_rd_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_start_i = 1'b0;
  logic [31:0] host_addr_i = '0;
  logic [15:0] host_nblk_i = '0;
  logic        host_busy_o, host_done_o, out_valid_o, cmd_start_o, rd_enable_o, rd_req_o;
  logic [1:0]  host_err_o;
  logic [7:0]  out_data_o;
  logic        out_ready_i = 1'b1;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic        cmd_done_i = 1'b0, cmd_err_i = 1'b0;
  logic        rd_ack_i = 1'b0;
  logic [7:0]  rd_data_i = '0;

  mmc_rd_sequencer #(.BYTE_ADDR(1)) dut (
    .clk(clk), .rst(rst),
    .host_start_i(host_start_i), .host_addr_i(host_addr_i), .host_nblk_i(host_nblk_i),
    .host_busy_o(host_busy_o), .host_done_o(host_done_o), .host_err_o(host_err_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .cmd_start_o(cmd_start_o), .cmd_index_o(cmd_index_o), .cmd_arg_o(cmd_arg_o),
    .cmd_done_i(cmd_done_i), .cmd_err_i(cmd_err_i),
    .rd_enable_o(rd_enable_o), .rd_req_o(rd_req_o), .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic cmd_err_sel = 1'b0;
  logic ready_mode = 1'b0;

  int cmd_cd, n_cmd, n_cmd12, stab_err;
  logic [5:0]  first_idx, last_idx;
  logic [31:0] first_arg, last_arg;
  always @(negedge clk) begin
    cmd_done_i = 1'b0;
    cmd_err_i  = 1'b0;
    if (rst) begin
      cmd_cd = 0; n_cmd = 0; n_cmd12 = 0; stab_err = 0;
      first_idx = '0; last_idx = '0; first_arg = '0; last_arg = '0;
    end else begin
      if (cmd_cd > 0) begin
        if (cmd_index_o !== last_idx) stab_err++;
        cmd_cd--;
        if (cmd_cd == 0) begin
          cmd_done_i = 1'b1;
          cmd_err_i  = last_idx == 6'd12 ? 1'b0 : cmd_err_sel;
        end
      end
      if (cmd_start_o) begin
        if (n_cmd == 0) begin first_idx = cmd_index_o; first_arg = cmd_arg_o; end
        last_idx = cmd_index_o;
        last_arg = cmd_arg_o;
        n_cmd++;
        if (cmd_index_o == 6'd12) n_cmd12++;
        cmd_cd = 3;
      end
    end
  end

  int rd_cd, eng_n, n_req, dbl, req_viol, en_fall, en_seen;
  logic outst, en_prev;
  always @(negedge clk) begin
    rd_ack_i = 1'b0;
    if (rst) begin
      rd_cd = 0; eng_n = 0; n_req = 0; dbl = 0; req_viol = 0; en_fall = 0; en_seen = 0;
      outst = 1'b0; en_prev = 1'b0;
    end else begin
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          rd_ack_i  = 1'b1;
          rd_data_i = eng_n[7:0];
          eng_n++;
          outst = 1'b0;
        end
      end
      if (rd_req_o) begin
        n_req++;
        if (outst || !rd_enable_o) dbl++;
        if (out_valid_o && (eng_n % 515) < 512) req_viol++;
        outst = 1'b1;
        rd_cd = 2;
      end
      if (rd_enable_o) en_seen++;
      if (en_prev && !rd_enable_o) en_fall++;
      en_prev = rd_enable_o;
    end
  end

  int rx_n, data_err, done_cnt, busy_at_done;
  logic [1:0] done_err;
  always @(negedge clk) begin
    out_ready_i = ready_mode ? ~out_ready_i : 1'b1;
    if (rst) begin
      rx_n = 0; data_err = 0; done_cnt = 0; busy_at_done = 0; done_err = '0;
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (out_data_o !== 8'(((rx_n / 512) * 515) + (rx_n % 512))) data_err++;
        rx_n++;
      end
      if (host_done_o) begin
        done_cnt++;
        done_err = host_err_o;
        if (host_busy_o) busy_at_done++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] nblk, input logic [31:0] addr);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    host_start_i = 1'b1;
    host_nblk_i  = nblk;
    host_addr_i  = addr;
    @(negedge clk);
    host_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 30000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk(tag, done_cnt, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", host_busy_o, 0);
    chk("rst_done", host_done_o, 0);
    chk("rst_err", host_err_o, 0);
    chk("rst_outs", {out_valid_o, cmd_start_o, rd_enable_o, rd_req_o}, 0);

    start(16'd1, 32'd5);
    chk("t1_busy", host_busy_o, 1);
    wait_done("t1_done");
    chk("t1_idx", first_idx, 17);
    chk("t1_arg", first_arg, 32'h0000_0A00);
    chk("t1_rx", rx_n, 512);
    chk("t1_data", data_err, 0);
    chk("t1_req", n_req, 515);
    chk("t1_cmd12", n_cmd12, 0);
    chk("t1_err", done_err, 0);
    chk("t1_busy_done", busy_at_done, 0);
    chk("t1_after_busy", host_busy_o, 0);

    start(16'd3, 32'h10);
    repeat (100) @(negedge clk);
    host_start_i = 1'b1;
    host_nblk_i  = 16'd1;
    @(negedge clk);
    host_start_i = 1'b0;
    wait_done("t2_done");
    chk("t2_idx", first_idx, 18);
    chk("t2_arg", first_arg, 32'h0000_2000);
    chk("t2_rx", rx_n, 1536);
    chk("t2_data", data_err, 0);
    chk("t2_req", n_req, 1545);
    chk("t2_en_fall", en_fall, 1);
    chk("t2_ncmd", n_cmd, 2);
    chk("t2_last_idx", last_idx, 12);
    chk("t2_last_arg", last_arg, 0);
    chk("t2_err", done_err, 0);
    chk("t2_stable", stab_err, 0);

    ready_mode = 1'b1;
    start(16'd1, 32'd7);
    wait_done("t3_done");
    ready_mode = 1'b0;
    chk("t3_rx", rx_n, 512);
    chk("t3_data", data_err, 0);
    chk("t3_viol", req_viol, 0);
    chk("t3_dbl", dbl, 0);

    cmd_err_sel = 1'b1;
    start(16'd1, 32'd9);
    wait_done("t4_done");
    cmd_err_sel = 1'b0;
    chk("t4_err", done_err, 1);
    chk("t4_en", en_seen, 0);
    chk("t4_rx", rx_n, 0);
    chk("t4_req", n_req, 0);

    start(16'd0, 32'd1);
    wait_done("t0_done");
    chk("t0_ncmd", n_cmd, 0);
    chk("t0_err", done_err, 0);

    start(16'd2, 32'd3);
    begin
      int k = 0;
      while (rx_n < 200 && k < 30000) begin
        @(negedge clk);
        k++;
      end
      chk("t6_reach", rx_n >= 200, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", host_busy_o, 0);
    chk("t6_rst_done", host_done_o, 0);
    chk("t6_rst_err", host_err_o, 0);
    chk("t6_rst_outs", {out_valid_o, cmd_start_o, rd_enable_o, rd_req_o}, 0);
    start(16'd1, 32'd5);
    wait_done("t6_done");
    chk("t6_rx", rx_n, 512);
    chk("t6_data", data_err, 0);
    chk("t6_err", done_err, 0);
    chk("t6_arg", first_arg, 32'h0000_0A00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
